ff64_bank_arb: RTL and testbench

FF64_BANK_ARB -- requirements
Module: ff64_bank_arb

---
 rtl/ff64_bank_arb_pkg.sv | 19 +
 rtl/ff64_rr_arb.sv | 32 +++
 rtl/ff64_bank_arb.sv | 141 ++++++++++++++
 tb/tb_ff64_bank_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff64_bank_arb_pkg.sv
// Shared defaults, width helper and FSM encoding for the arbitrated 64-bit bank.
package ff64_bank_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int N_WORDS_DEF = 16;
    localparam int WORD_W      = 64;

    // Index width for n items; never below 1 so single-entry configs still get a port bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ff64_rr_arb.sv
// Round-robin one-hot picker: first eligible requester at or after ptr, wrapping.
module ff64_rr_arb #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0]   elig_rot;
    logic [N_REQ-1:0]   pick_rot;
    logic [2*N_REQ-1:0] pick_dbl;
    logic               found;

    // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        elig_rot = N_REQ'({2{req & ~mask}} >> ptr);
        pick_rot = '0;
        found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig_rot[i]) begin
                pick_rot[i] = 1'b1;
                found       = 1'b1;
            end
        end
        pick_dbl = {{N_REQ{1'b0}}, pick_rot} << ptr;
        grant    = pick_dbl[N_REQ-1:0] | pick_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/ff64_bank_arb.sv
// Multi-requester write arbiter in front of a bank of 64-bit words with valid
// tracking and a sequenced bank clear.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | arbitrating writes; clear moves to ST_FLUSH
// ST_FLUSH | one cycle for the last grant's ack to drain; no grants
// ST_CLEAR | zero every word and valid bit; no grants; back to ST_RUN
module ff64_bank_arb
    import ff64_bank_arb_pkg::*;
#(
    parameter int  N_REQ   = N_REQ_DEF,
    parameter int  N_WORDS = N_WORDS_DEF,
    localparam int ADDR_W  = idx_w(N_WORDS)
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*WORD_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    input  logic                    clear,
    output logic                    busy,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [WORD_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    all_valid
);

    localparam int PTR_W = idx_w(N_REQ);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [N_REQ-1:0]   arb_grant;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   ack_q;
    logic               bank_clr;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WORD_W-1:0]  wr_data;
    logic [WORD_W-1:0]  bank_q [N_WORDS];
    logic [N_WORDS-1:0] valid_q;

    // Requesters currently being acked are masked so a still-high request is not granted twice.
    ff64_rr_arb #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req   (req_wr),
        .mask  (ack_q),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        state_d  = state_q;
        grant    = '0;
        bank_clr = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_RUN: begin
                grant = arb_grant;
                if (clear) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy    = 1'b1;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                bank_clr = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        ptr_d   = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                wr_en   = (int'(req_addr[i*ADDR_W +: ADDR_W]) < N_WORDS);
                wr_addr = req_addr[i*ADDR_W +: ADDR_W];
                wr_data = req_data[i*WORD_W +: WORD_W];
                ptr_d   = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= grant;
        end
    end

    for (genvar w = 0; w < N_WORDS; w++) begin : g_word
        logic [WORD_W-1:0] word_q;
        logic              vld_q;

        always_ff @(posedge CLK) begin
            if (!rst_n || bank_clr) begin
                word_q <= '0;
                vld_q  <= 1'b0;
            end else if (wr_en && (wr_addr == ADDR_W'(w))) begin
                word_q <= wr_data;
                vld_q  <= 1'b1;
            end
        end

        assign bank_q[w]  = word_q;
        assign valid_q[w] = vld_q;
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (int'(rd_addr) < N_WORDS) begin
            rd_data  = bank_q[rd_addr];
            rd_valid = valid_q[rd_addr];
        end
    end

    assign all_valid = &valid_q;
    assign req_ack   = ack_q;

endmodule

// File: tb/tb_ff64_bank_arb.sv
// Self-checking bench for ff64_bank_arb: directed table, corner sequences, random vs reference model.
module tb_ff64_bank_arb;

    localparam int NR = 4;
    localparam int NW = 16;
    localparam int AW = 4;

    logic           CLK = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_wr;
    logic [NR*AW-1:0] req_addr;
    logic [NR*64-1:0] req_data;
    logic [NR-1:0]  req_ack;
    logic           clear;
    logic           busy;
    logic [AW-1:0]  rd_addr;
    logic [63:0]    rd_data;
    logic           rd_valid;
    logic           all_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_bank [NW];
    logic        m_valid [NW];
    int          m_ptr;
    int          m_busy_left;
    logic [3:0]  m_ack;

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic [3:0] ack;
        logic       bsy;
    } vec_t;

    vec_t       tbl [12];
    logic [3:0] active;
    int         bcnt;

    always #5 CLK = ~CLK;

    ff64_bank_arb dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .clear     (clear),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .all_valid (all_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic m_all_valid();
        logic r;
        r = 1'b1;
        for (int w = 0; w < NW; w++) r = r & m_valid[w];
        return r;
    endfunction

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [3:0] nack;
        logic [3:0] a;
        int         start;
        int         idx;
        nack = '0;
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) begin
                m_bank[w]  = '0;
                m_valid[w] = 1'b0;
            end
            m_ptr       = 0;
            m_busy_left = 0;
            m_ack       = '0;
        end else if (m_busy_left > 0) begin
            if (m_busy_left == 1) begin
                for (int w = 0; w < NW; w++) begin
                    m_bank[w]  = '0;
                    m_valid[w] = 1'b0;
                end
            end
            m_busy_left--;
            m_ack = '0;
        end else begin
            start = m_ptr;
            for (int j = 0; j < NR; j++) begin
                idx = (start + j) % NR;
                if (nack == 4'd0 && req_wr[idx] && !m_ack[idx]) begin
                    nack[idx]  = 1'b1;
                    a          = req_addr[idx*AW +: AW];
                    m_bank[a]  = req_data[idx*64 +: 64];
                    m_valid[a] = 1'b1;
                    m_ptr      = (idx + 1) % NR;
                end
            end
            m_ack = nack;
            if (clear) m_busy_left = 2;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        chk("ack", 64'(req_ack), 64'(m_ack));
        chk("busy", 64'(busy), 64'(m_busy_left > 0));
        chk("all_valid", 64'(all_valid), 64'(m_all_valid()));
        chk("rd_data", rd_data, m_bank[rd_addr]);
        chk("rd_valid", 64'(rd_valid), 64'(m_valid[rd_addr]));
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [63:0] d, input logic v);
        rd_addr = a;
        #1;
        chk({name, "_data"}, rd_data, d);
        chk({name, "_valid"}, 64'(rd_valid), 64'(v));
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [63:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*64 +: 64] = d;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_wr = '0;
        clear  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        req_wr   = '0;
        req_addr = '0;
        req_data = '0;
        rd_addr  = '0;
        active   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_all_valid", 64'(all_valid), 64'd0);
        rd_chk("rst_rd", 4'd3, 64'd0, 1'b0);

        // Single write from requester 0
        set_req(0, 4'd3, 64'hDEADBEEF_01234567);
        req_wr = 4'b0001;
        tick();
        chk("a_ack", 64'(req_ack), 64'h1);
        req_wr = '0;
        rd_chk("a_rd", 4'd3, 64'hDEADBEEF_01234567, 1'b1);
        tick();
        chk("a_ack_pulse", 64'(req_ack), 64'h0);

        // Same-address collision: later grant wins
        do_reset();
        set_req(1, 4'd5, 64'hAAAA_AAAA_0000_0001);
        set_req(2, 4'd5, 64'hBBBB_BBBB_0000_0002);
        req_wr = 4'b0110;
        tick();
        chk("b_ack1", 64'(req_ack), 64'h2);
        req_wr = 4'b0100;
        rd_chk("b_first", 4'd5, 64'hAAAA_AAAA_0000_0001, 1'b1);
        tick();
        chk("b_ack2", 64'(req_ack), 64'h4);
        req_wr = '0;
        rd_chk("b_last", 4'd5, 64'hBBBB_BBBB_0000_0002, 1'b1);

        // Directed table: round-robin order, masking, clear in a grant cycle, pointer kept across clear
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 4'(8 + i), {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i)});
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b0};
        tbl[2]  = '{4'b1110, 1'b0, 4'b0100, 1'b0};
        tbl[3]  = '{4'b1100, 1'b0, 4'b1000, 1'b0};
        tbl[4]  = '{4'b1001, 1'b0, 4'b0001, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[8]  = '{4'b0011, 1'b0, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0011, 1'b0, 4'b0010, 1'b0};
        tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        for (int r = 0; r < 12; r++) begin
            req_wr = tbl[r].req;
            clear  = tbl[r].clr;
            tick();
            chk($sformatf("tbl%0d_ack", r), 64'(req_ack), 64'(tbl[r].ack));
            chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].bsy));
        end
        clear = 1'b0;

        // Grant and clear in the same cycle
        set_req(0, 4'd7, 64'h0000_0000_00C0_FFEE);
        req_wr = 4'b0001;
        clear  = 1'b1;
        tick();
        chk("c_ack", 64'(req_ack), 64'h1);
        chk("c_busy1", 64'(busy), 64'd1);
        req_wr = '0;
        clear  = 1'b0;
        rd_chk("c_wr", 4'd7, 64'h0000_0000_00C0_FFEE, 1'b1);
        tick();
        chk("c_busy2", 64'(busy), 64'd1);
        tick();
        chk("c_busy3", 64'(busy), 64'd0);
        rd_chk("c_clr", 4'd7, 64'd0, 1'b0);
        chk("c_all_valid", 64'(all_valid), 64'd0);

        // Fill all words, then double clear pulse
        for (int a = 0; a < NW; a++) begin
            set_req(a % NR, 4'(a), {32'h5A5A_0000 + 32'(a), 32'hF00D_0000 + 32'(a)});
            req_wr = 4'(1 << (a % NR));
            tick();
            chk($sformatf("d_ack%0d", a), 64'(req_ack), 64'(1 << (a % NR)));
            req_wr = '0;
            chk($sformatf("d_all_valid%0d", a), 64'(all_valid), 64'(a == NW - 1));
            tick();
        end
        bcnt  = 0;
        clear = 1'b1;
        tick();
        if (busy) bcnt++;
        tick();
        if (busy) bcnt++;
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy) bcnt++;
        end
        chk("d_busy_cycles", 64'(bcnt), 64'd2);
        chk("d_all_valid_clr", 64'(all_valid), 64'd0);

        // Reset in the middle of a burst
        for (int i = 0; i < NR; i++) set_req(i, 4'(10 + i), {32'hE000_0000 + 32'(i), 32'hE111_0000 + 32'(i)});
        req_wr = 4'b1111;
        tick();
        req_wr = 4'b1110;
        tick();
        req_wr = 4'b1100;
        rst_n  = 1'b0;
        tick();
        chk("e_rst_ack", 64'(req_ack), 64'd0);
        chk("e_rst_all_valid", 64'(all_valid), 64'd0);
        rst_n  = 1'b1;
        req_wr = '0;
        tick();
        chk("e_no_ack", 64'(req_ack), 64'd0);
        for (int a = 0; a < NW; a++) begin
            rd_addr = 4'(a);
            tick();
            chk($sformatf("e_rd%0d", a), rd_data, 64'd0);
        end
        req_wr = 4'b1111;
        tick();
        chk("e_ptr_restart", 64'(req_ack), 64'h1);
        req_wr = 4'b1110;
        tick();
        req_wr = 4'b1100;
        tick();
        req_wr = 4'b1000;
        tick();
        req_wr = '0;
        tick();

        // Random traffic against the reference model
        active = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (active[i] && m_ack[i]) begin
                    active[i] = 1'b0;
                end else if (!active[i] && !m_ack[i] && $urandom_range(0, 2) == 0) begin
                    active[i] = 1'b1;
                    set_req(i, 4'($urandom_range(0, 15)), {$urandom, $urandom});
                end
            end
            req_wr  = active;
            clear   = ($urandom_range(0, 24) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            rd_addr = 4'($urandom_range(0, 15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
